// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the iterative multiply/divide unit: datapath width,
// iteration count, operation encodings and FSM state encodings.
// -----------------------------------------------------------------------------
package muldiv_pkg;

  localparam int unsigned MULDIV_WIDTH = 32;
  localparam int unsigned MULDIV_ITERS = 32;
  localparam int unsigned MULDIV_CNT_W = $clog2(MULDIV_ITERS);

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RUN    = 2'b01,
    S_FINISH = 2'b10
  } state_e;

  // Bit 0 of the encoding selects unsigned, bit 1 selects divide.
  function automatic logic op_is_signed(input op_e op);
    return ~op[0];
  endfunction

  function automatic logic op_is_div(input op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// -----------------------------------------------------------------------------
// muldiv_core
// Iterative radix-2 datapath. Works on operand magnitudes: shift-add for
// multiply, restoring division for divide, one step per i_step cycle. The
// signed result is produced combinationally from the accumulator by a final
// sign fix-up.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   i_load           capture op and operands, initialise accumulator
//   i_step           perform one iteration
//   i_op             operation (muldiv_pkg::op_e)
//   i_a, i_b         operands (rs, rt)
//   o_hi, o_lo       fixed-up result (product hi/lo or remainder/quotient)
// -----------------------------------------------------------------------------
module muldiv_core
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_step,
  input  op_e              i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  // Accumulator: multiply -> {partial product, remaining multiplier};
  //              divide   -> {partial remainder, dividend/quotient bits}.
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_b;
  logic               r_div;
  logic               r_neg_q;   // negate product / quotient
  logic               r_neg_r;   // negate remainder (dividend negative)
  logic               r_b_zero;

  logic               w_signed;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;

  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [WIDTH:0]     w_div_tmp;
  logic               w_div_ge;
  logic [WIDTH-1:0]   w_div_sub;
  logic [2*WIDTH-1:0] w_div_next;

  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;

  assign w_signed = op_is_signed(i_op);
  // -2^31 has magnitude 2^31, which still fits as an unsigned WIDTH-bit value.
  assign w_a_mag  = (w_signed && i_a[WIDTH-1]) ? -i_a : i_a;
  assign w_b_mag  = (w_signed && i_b[WIDTH-1]) ? -i_b : i_b;

  // Shift-add: add the multiplicand when the multiplier LSB is set, then shift
  // the whole accumulator right, keeping the carry out of the add.
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_b : '0)};
  assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Restoring divide: the shifted partial remainder needs WIDTH+1 bits because
  // the divisor may use the full unsigned range.
  assign w_div_tmp  = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_div_ge   = (w_div_tmp >= {1'b0, r_b});
  assign w_div_sub  = w_div_tmp[WIDTH-1:0] - r_b;
  assign w_div_next = {(w_div_ge ? w_div_sub : w_div_tmp[WIDTH-1:0]),
                       r_acc[WIDTH-2:0], w_div_ge};

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the datapath is reset as well, so an aborted operation leaves no
    // partial result behind.
    if (!rst_n) begin
      r_acc    <= '0;
      r_b      <= '0;
      r_div    <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_b_zero <= 1'b0;
    end else if (i_load) begin
      // NOTE: non-blocking assignments make every register here sample the
      // pre-edge values, independent of statement order.
      r_acc    <= {{WIDTH{1'b0}}, w_a_mag};
      r_b      <= w_b_mag;
      r_div    <= op_is_div(i_op);
      r_neg_q  <= w_signed & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
      r_neg_r  <= w_signed & i_a[WIDTH-1];
      r_b_zero <= (i_b == '0);
    end else if (i_step) begin
      r_acc    <= r_div ? w_div_next : w_mul_next;
    end
  end

  assign w_prod = r_neg_q ? -r_acc : r_acc;
  assign w_quot = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

  // Divide by zero: quotient is all ones; the remainder already equals the
  // dividend magnitude and its sign fix-up restores OperandA exactly.
  always_comb begin
    o_hi = w_prod[2*WIDTH-1:WIDTH];
    o_lo = w_prod[WIDTH-1:0];
    if (r_div) begin
      o_hi = w_rem;
      o_lo = r_b_zero ? '1 : w_quot;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// MIPS-style HI/LO multiply/divide unit. A Start in IDLE captures the operands
// and runs 32 radix-2 iterations; the FINISH cycle presents the result on
// Hi/Lo with a one-cycle Done pulse, then the unit returns to IDLE.
// mthi/mtlo writes are accepted only in IDLE with Start low.
//
// Ports:
//   Clk, Reset_n         clock, asynchronous active-low reset
//   Start, Op            start request and operation (mult/multu/div/divu)
//   OperandA, OperandB   rs / rt values
//   MtHi, MtLo, MtData   move-to-HI/LO controls and data
//   Busy, Done           operation in progress / completion pulse
//   Hi, Lo              HI and LO registers
// -----------------------------------------------------------------------------
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] OperandA,
  input  logic [WIDTH-1:0] OperandB,
  input  logic             MtHi,
  input  logic             MtLo,
  input  logic [WIDTH-1:0] MtData,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  state_e                  r_state;
  state_e                  w_next_state;
  logic [MULDIV_CNT_W-1:0] r_count;
  logic [WIDTH-1:0]        r_hi;
  logic [WIDTH-1:0]        r_lo;
  logic [WIDTH-1:0]        w_core_hi;
  logic [WIDTH-1:0]        w_core_lo;
  logic                    w_accept;
  logic                    w_step;
  logic                    w_mt_ok;

  assign w_accept = (r_state == S_IDLE) && Start;
  assign w_step   = (r_state == S_RUN);
  // A simultaneous Start wins over a move.
  assign w_mt_ok  = (r_state == S_IDLE) && !Start;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    w_next_state = r_state;
    Busy         = 1'b1;
    Done         = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        Busy = 1'b0;
        if (Start) w_next_state = S_RUN;
      end
      S_RUN: begin
        if (r_count == MULDIV_CNT_W'(MULDIV_ITERS - 1)) w_next_state = S_FINISH;
      end
      S_FINISH: begin
        Done         = 1'b1;
        w_next_state = S_IDLE;
      end
      default: begin
        Busy         = 1'b0;
        w_next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)      r_count <= '0;
    else if (w_accept) r_count <= '0;
    else if (w_step)   r_count <= r_count + MULDIV_CNT_W'(1);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (r_state == S_FINISH) begin
      r_hi <= w_core_hi;
      r_lo <= w_core_lo;
    end else if (w_mt_ok) begin
      if (MtHi) r_hi <= MtData;
      if (MtLo) r_lo <= MtData;
    end
  end

  // The result is visible during the Done cycle itself and is then held in
  // r_hi/r_lo from the FINISH->IDLE edge onwards.
  assign Hi = (r_state == S_FINISH) ? w_core_hi : r_hi;
  assign Lo = (r_state == S_FINISH) ? w_core_lo : r_lo;

  muldiv_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk    (Clk),
    .rst_n  (Reset_n),
    .i_load (w_accept),
    .i_step (w_step),
    .i_op   (op_e'(Op)),
    .i_a    (OperandA),
    .i_b    (OperandB),
    .o_hi   (w_core_hi),
    .o_lo   (w_core_lo)
  );

endmodule
